// File: rtl/psum_rearrange_pkg.sv
// ---------------------------------------------------------------------------
// psum_rearrange_pkg: shared widths, int8 limits, FSM state type, saturator.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package psum_rearrange_pkg;

  localparam int PSUM_W   = 32;
  localparam int ADDR_W   = 12;
  localparam int DEPTH    = 3500;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic signed [7:0] sat_int8(input logic signed [PSUM_W:0] y);
    if (y > (PSUM_W+1)'(INT8_MAX))
      sat_int8 = 8'(INT8_MAX);
    else if (y < (PSUM_W+1)'(INT8_MIN))
      sat_int8 = 8'(INT8_MIN);
    else
      sat_int8 = y[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_requant_writer_if.sv
// ---------------------------------------------------------------------------
// psum_requant_writer_if: psum input stream plus rearrange-buffer write bus.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface psum_requant_writer_if;

  logic signed [psum_rearrange_pkg::PSUM_W-1:0] psum_in;
  logic                                         psum_in_valid;
  logic                                         psum_in_ready;
  logic                                         write_en;
  logic        [psum_rearrange_pkg::ADDR_W-1:0] write_addr;
  logic signed [7:0]                            data_out;
  logic                                         data_out_valid;

  // master: psum bank / rearrange buffer side; slave: the writer block
  modport master (
    output psum_in, psum_in_valid,
    input  psum_in_ready, write_en, write_addr, data_out, data_out_valid
  );

  modport slave (
    input  psum_in, psum_in_valid,
    output psum_in_ready, write_en, write_addr, data_out, data_out_valid
  );

endinterface

`default_nettype wire

// File: rtl/psum_requant.sv
// ---------------------------------------------------------------------------
// psum_requant: S1 ReLU + round-half-up arithmetic shift, S2 int8 saturate.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module psum_requant
  import psum_rearrange_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [PSUM_W-1:0] psum,
  input  logic        [4:0]        shift,
  input  logic                     relu_en,
  input  logic        [ADDR_W-1:0] addr_in,
  output logic                     out_valid,
  output logic signed [7:0]        data,
  output logic        [ADDR_W-1:0] addr_out
);

  logic signed [PSUM_W:0]   w_x;
  logic signed [PSUM_W:0]   w_round;
  logic signed [PSUM_W:0]   w_y;
  logic        [4:0]        w_sm1;
  logic signed [PSUM_W:0]   r_y;
  logic        [ADDR_W-1:0] r_addr1;
  logic                     r_v1;

  // One extra bit of headroom so adding the rounding constant never overflows
  always_comb begin
    w_x     = (relu_en && psum[PSUM_W-1]) ? '0 : {psum[PSUM_W-1], psum};
    w_sm1   = shift - 5'd1;
    w_round = {{PSUM_W{1'b0}}, 1'b1} << w_sm1;
    w_y     = (shift == 5'd0) ? w_x : ((w_x + w_round) >>> shift);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_y       <= '0;
      r_addr1   <= '0;
      out_valid <= 1'b0;
      data      <= '0;
      addr_out  <= '0;
    end else begin
      r_v1      <= in_valid;
      out_valid <= r_v1;
      if (in_valid) begin
        r_y     <= w_y;
        r_addr1 <= addr_in;
      end
      if (r_v1) begin
        data     <= sat_int8(r_y);
        addr_out <= r_addr1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/psum_requant_writer.sv
// ---------------------------------------------------------------------------
// psum_requant_writer: drains channel-major psums, requantises to int8 and
// writes them pixel-interleaved (addr = pix*num_ch + ch). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module psum_requant_writer
  import psum_rearrange_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [3:0]                  cfg_num_ch,
  input  logic [9:0]                  cfg_num_pix,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_relu_en,
  psum_requant_writer_if.slave        bus,
  output logic                        busy,
  output logic                        done
);

  state_t              r_state;
  logic [3:0]          r_num_ch;
  logic [9:0]          r_num_pix;
  logic [4:0]          r_shift;
  logic                r_relu_en;
  logic [3:0]          r_ch;
  logic [9:0]          r_pix;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_last_pix;
  logic                w_last_ch;
  logic                w_out_valid;

  assign w_accept   = bus.psum_in_valid & r_ready;
  assign w_last_pix = (r_pix == r_num_pix - 10'd1);
  assign w_last_ch  = (r_ch == r_num_ch - 4'd1);

  assign bus.psum_in_ready  = r_ready;
  assign bus.write_en       = w_out_valid;
  assign bus.data_out_valid = w_out_valid;
  assign busy               = r_busy;
  assign done               = r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_num_ch  <= '0;
      r_num_pix <= '0;
      r_shift   <= '0;
      r_relu_en <= 1'b0;
      r_ch      <= '0;
      r_pix     <= '0;
      r_addr    <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num_ch  <= cfg_num_ch;
            r_num_pix <= cfg_num_pix;
            r_shift   <= cfg_shift;
            r_relu_en <= cfg_relu_en;
            r_ch      <= '0;
            r_pix     <= '0;
            r_addr    <= '0;
            if (cfg_num_ch == 4'd0 || cfg_num_pix == 10'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_pix  <= '0;
              r_ch   <= r_ch + 4'd1;
              r_addr <= ADDR_W'(r_ch) + ADDR_W'(1);
              if (w_last_ch) begin
                r_state <= DRAIN;
                r_ready <= 1'b0;
              end
            end else begin
              r_pix  <= r_pix + 10'd1;
              r_addr <= r_addr + ADDR_W'(r_num_ch);
            end
          end
        end
        // Only the final psum can be in flight here (sitting in S1); it reaches
        // S2 on this edge, so done lines up with its write strobe.
        DRAIN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  psum_requant u_requant (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_accept),
    .psum      (bus.psum_in),
    .shift     (r_shift),
    .relu_en   (r_relu_en),
    .addr_in   (r_addr),
    .out_valid (w_out_valid),
    .data      (bus.data_out),
    .addr_out  (bus.write_addr)
  );

endmodule

`default_nettype wire
